// File: rtl/node_mem_responder.sv
// ============================================================================
// Module   : node_mem_responder
// Purpose  : Round-robin BRAM responder shared by octree builder and DFS engine
// Revision : 1.0
// ============================================================================
`default_nettype none

module node_mem_responder #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_W    = 64,
    parameter int RD_LAT    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_oct_req,
    input  logic                 i_oct_we,
    input  logic [ADDR_SIZE-1:0] i_oct_addr,
    input  logic [DATA_W-1:0]    i_oct_wdata,
    output logic                 o_oct_gnt,
    output logic                 o_oct_rvalid,
    output logic [DATA_W-1:0]    o_oct_rdata,
    input  logic                 i_dfs_req,
    input  logic [ADDR_SIZE-1:0] i_dfs_addr,
    output logic                 o_dfs_gnt,
    output logic                 o_dfs_rvalid,
    output logic [DATA_W-1:0]    o_dfs_rdata,
    output logic                 o_mem_en,
    output logic                 o_mem_we,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    output logic [DATA_W-1:0]    o_mem_wdata,
    input  logic [DATA_W-1:0]    i_mem_rdata,
    output logic                 o_sel,
    output logic                 o_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    logic [1:0]           state;
    logic                 last_dfs;
    logic                 cmd_dfs;
    logic                 cmd_we;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [DATA_W-1:0]    cmd_wdata;
    logic [2:0]           lat_cnt;
    logic                 sel;
    logic                 oct_rvalid;
    logic                 dfs_rvalid;
    logic [DATA_W-1:0]    oct_rdata;
    logic [DATA_W-1:0]    dfs_rdata;
    logic                 pick_dfs;
    logic                 pick_wr;
    logic                 issue;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        pick_dfs = i_dfs_req && (!i_oct_req || !last_dfs);
        pick_wr  = !pick_dfs && i_oct_we;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            last_dfs   <= 1'b1;
            cmd_dfs    <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            lat_cnt    <= '0;
            sel        <= 1'b0;
            oct_rvalid <= 1'b0;
            dfs_rvalid <= 1'b0;
            oct_rdata  <= '0;
            dfs_rdata  <= '0;
        end else begin
            oct_rvalid <= 1'b0;
            dfs_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_oct_req || i_dfs_req) begin
                        cmd_dfs   <= pick_dfs;
                        cmd_we    <= pick_wr;
                        cmd_addr  <= pick_dfs ? i_dfs_addr : i_oct_addr;
                        cmd_wdata <= pick_wr ? i_oct_wdata : '0;
                        sel       <= pick_dfs;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    last_dfs <= cmd_dfs;
                    lat_cnt  <= '0;
                    state    <= cmd_we ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data is on the bus in the last counted cycle.
                    if (lat_cnt == LAT_LAST) begin
                        if (cmd_dfs) begin
                            dfs_rdata  <= i_mem_rdata;
                            dfs_rvalid <= 1'b1;
                        end else begin
                            oct_rdata  <= i_mem_rdata;
                            oct_rvalid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        issue        = (state == ST_ISSUE);
        o_oct_gnt    = issue && !cmd_dfs;
        o_dfs_gnt    = issue && cmd_dfs;
        o_mem_en     = issue;
        o_mem_we     = issue && cmd_we;
        o_mem_addr   = issue ? cmd_addr : '0;
        o_mem_wdata  = issue ? cmd_wdata : '0;
        o_oct_rvalid = oct_rvalid;
        o_dfs_rvalid = dfs_rvalid;
        o_oct_rdata  = oct_rdata;
        o_dfs_rdata  = dfs_rdata;
        o_sel        = sel;
        o_busy       = (state != ST_IDLE);
    end

endmodule

`default_nettype wire
